jt51_sh_port: RTL and testbench

Slot-addressed access port for a time-multiplexed recirculating register ring. The ring holds `stages` words of `width` bits and rotates by one slot on every `cen`, presenting the head word to the synthesis pipeline on `dout` together with its slot number. A register-interface client writes or reads one slot at a time through a request/acknowledge handshake. The port waits until the addressed slot reaches the head, then either loads new data in place of recirculation or captures the head word.

---
 rtl/jt51_sh_pkg.sv | 18 +
 rtl/jt51_sh_ring.sv | 39 +++
 rtl/jt51_sh_port.sv | 116 +++++++++++
 tb/tb_jt51_sh_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_sh_pkg.sv
// Shared definitions for the slot-addressed ring access port.
// Contents:
//   state_t - handshake FSM encoding (idle / pending / done)
//   op_t    - latched request type (write / read)
package jt51_sh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // ready to accept a request
    ST_PEND = 2'd1,  // waiting for the addressed slot to reach the head
    ST_DONE = 2'd2   // one-cycle acknowledge
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/jt51_sh_ring.sv
// Recirculating register ring: stages words of width bits. On every cen the
// ring shifts one word toward the head. The word leaving the head re-enters
// at the tail, unless load is set, in which case load_data enters instead.
// Ports:
//   clk, rst        - clock, synchronous active-high clear
//   cen             - advance the ring by one slot
//   load, load_data - replace the recirculated word at the tail
//   head            - word currently at the head of the ring
module jt51_sh_ring #(
  parameter int width  = 5,
  parameter int stages = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             load,
  input  logic [width-1:0] load_data,
  output logic [width-1:0] head
);

  logic [width-1:0] mem [stages];

  // NOTE: every word is a plain flop in a shift chain, not a RAM macro, so a
  // full synchronous clear is cheap and legal. Do not copy this reset style
  // onto a real memory array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) mem[i] <= '0;
    end else if (cen) begin
      // NOTE: non-blocking assignments make every stage read the old value of
      // its neighbour, so the whole chain shifts as one register.
      for (int i = 0; i < stages - 1; i++) mem[i] <= mem[i+1];
      mem[stages-1] <= load ? load_data : mem[0];
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/jt51_sh_port.sv
// Slot-addressed access port for a time-multiplexed recirculating ring.
// The ring rotates on cen; slot/dout present the head word and its index.
// A client issues one read or write at a time; the port waits for the slot
// to reach the head, then loads new data at the tail (write) or captures the
// head word (read), and pulses ack for one cycle.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cen                - ring advance enable
//   slot, dout         - head slot index and head word
//   wr_req, rd_req     - requests, sampled only while busy=0 (write wins)
//   addr, wdata        - target slot and write data
//   rdata              - last serviced read result
//   busy, ack, err     - request pending, completion pulse, rejected address
module jt51_sh_port
  import jt51_sh_pkg::*;
#(
  parameter int width  = 5,
  parameter int stages = 32,
  parameter int AW     = $clog2(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  output logic [AW-1:0]    slot,
  output logic [width-1:0] dout,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [AW-1:0]    addr,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             busy,
  output logic             ack,
  output logic             err
);

  localparam logic [AW-1:0] last_slot  = AW'(stages - 1);
  localparam logic [AW:0]   stages_ext = (AW+1)'(stages);

  state_t           state, state_nx;
  op_t              op_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    cnt;
  logic [width-1:0] wdata_q;
  logic [width-1:0] head;
  logic             err_q;
  logic             req;
  logic             bad_addr;
  logic             hit;

  assign req      = wr_req | rd_req;
  assign bad_addr = {1'b0, addr} >= stages_ext;
  // Only evaluated in PEND, so a slot already at the head when the request is
  // accepted is serviced a full rotation later.
  assign hit      = (state == ST_PEND) && cen && (cnt == addr_q);

  jt51_sh_ring #(
    .width (width),
    .stages(stages)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .load     (hit && (op_q == OP_WR)),
    .load_data(wdata_q),
    .head     (head)
  );

  // Slot counter tracks which slot sits at the head of the ring.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (cen) cnt <= (cnt == last_slot) ? '0 : cnt + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (req) state_nx = bad_addr ? ST_DONE : ST_PEND;
      ST_PEND: if (hit) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture and read result.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_WR;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      if ((state == ST_IDLE) && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_q    <= wr_req ? OP_WR : OP_RD;
        err_q   <= bad_addr;
      end
      if (hit && (op_q == OP_RD)) rdata <= head;
    end
  end

  assign slot = cnt;
  assign dout = head;
  assign busy = (state != ST_IDLE);
  assign ack  = (state == ST_DONE);
  assign err  = ack & err_q;

endmodule

// File: tb/tb_jt51_sh_port.sv
// Self-checking bench for jt51_sh_port. A 32-slot instance carries the main
// tests; a 24-slot instance exercises rejected addresses. The reference model
// keeps the ring as a plain array indexed by slot number plus the head index.
module tb_jt51_sh_port;

  localparam int S    = 32;
  localparam int S24  = 24;
  localparam int W    = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic [4:0]   slot, slot24;
  logic [W-1:0] dout, dout24;
  logic         wr_req, rd_req, wr24, rd24;
  logic [4:0]   addr, addr24;
  logic [W-1:0] wdata, wdata24;
  logic [W-1:0] rdata, rdata24;
  logic         busy, ack, err, busy24, ack24, err24;

  jt51_sh_port #(.width(W), .stages(S)) dut (
    .clk(clk), .rst(rst), .cen(cen), .slot(slot), .dout(dout),
    .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .ack(ack), .err(err)
  );

  jt51_sh_port #(.width(W), .stages(S24)) dut24 (
    .clk(clk), .rst(rst), .cen(cen), .slot(slot24), .dout(dout24),
    .wr_req(wr24), .rd_req(rd24), .addr(addr24), .wdata(wdata24),
    .rdata(rdata24), .busy(busy24), .ack(ack24), .err(err24)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  // Reference model.
  int m_ring [S];
  int m_cnt   = 0;
  int m_cnt24 = 0;
  int m_rdata = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model follows the inputs presented for this edge.
  task automatic tick();
    if (rst) begin
      m_cnt = 0; m_cnt24 = 0; m_rdata = 0;
      for (int i = 0; i < S; i++) m_ring[i] = 0;
    end else if (cen) begin
      m_cnt   = (m_cnt + 1) % S;
      m_cnt24 = (m_cnt24 + 1) % S24;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_head();
    check("slot", int'(slot), m_cnt);
    check("dout", int'(dout), m_ring[m_cnt]);
    check("slot24", int'(slot24), m_cnt24);
    check("dout24", int'(dout24), 0);
  endtask

  // One transaction on the 32-slot port with cen held high. exp_edges is the
  // number of clock edges after acceptance until ack is visible.
  task automatic do_op(input bit w, input bit r, input int a, input int d,
                       input int exp_edges, input int exp_rdata, input bit junk);
    cen = 1'b1; wr_req = w; rd_req = r; addr = 5'(a); wdata = 5'(d);
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    for (int k = 1; k <= exp_edges; k++) begin
      check("busy_pending", int'(busy), 1);
      check("ack_early", int'(ack), 0);
      check_head();
      if (junk && k < exp_edges) begin
        wr_req = 1'($urandom_range(0, 1));
        rd_req = 1'($urandom_range(0, 1));
        addr   = 5'($urandom_range(0, 31));
        wdata  = 5'($urandom_range(0, 31));
      end else begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    if (w) m_ring[a] = d;
    check("ack", int'(ack), 1);
    check("err", int'(err), 0);
    check("busy_done", int'(busy), 1);
    if (w) check("rdata_hold", int'(rdata), m_rdata);
    else begin
      check("rdata", int'(rdata), exp_rdata);
      m_rdata = exp_rdata;
    end
    check_head();
    tick();
    check("ack_pulse", int'(ack), 0);
    check("busy_idle", int'(busy), 0);
    check("err_idle", int'(err), 0);
    check_head();
  endtask

  typedef struct {
    bit w;
    bit r;
    int a;
    int d;
    int start;   // head slot when the request is presented
    int edges;   // expected edges from acceptance to visible ack
    int rdata;
    bit junk;    // drive ignored requests while busy
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{w:1, r:0, a:5,  d:26, start:2,  edges:3,  rdata:0,  junk:0};
    vecs[1] = '{w:0, r:1, a:5,  d:0,  start:5,  edges:32, rdata:26, junk:0};
    vecs[2] = '{w:1, r:1, a:9,  d:3,  start:0,  edges:9,  rdata:0,  junk:1};
    vecs[3] = '{w:0, r:1, a:9,  d:0,  start:20, edges:21, rdata:3,  junk:0};
    vecs[4] = '{w:0, r:1, a:0,  d:0,  start:31, edges:1,  rdata:0,  junk:0};
    vecs[5] = '{w:1, r:0, a:31, d:31, start:30, edges:1,  rdata:0,  junk:0};
    vecs[6] = '{w:0, r:1, a:31, d:0,  start:0,  edges:31, rdata:31, junk:0};

    for (int i = 0; i < S; i++) m_ring[i] = 0;
    rst = 1'b1; cen = 1'b1;
    wr_req = 1'b1; rd_req = 1'b0; addr = 5'd3; wdata = 5'd7;
    wr24 = 1'b0; rd24 = 1'b0; addr24 = '0; wdata24 = '0;

    // Reset wins over cen and a pending request.
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0; wr_req = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    check("rst_rdata", int'(rdata), 0);
    check_head();

    // Free-running rotation: slot wraps, everything idle and zero.
    for (int i = 0; i < S + 1; i++) begin
      check("idle_busy", int'(busy), 0);
      check("idle_ack", int'(ack), 0);
      check_head();
      tick();
    end

    // Rejected addresses on the 24-slot instance.
    wr24 = 1'b1; addr24 = 5'd30; wdata24 = 5'd7;
    tick();
    wr24 = 1'b0;
    check("rej_wr_ack", int'(ack24), 1);
    check("rej_wr_err", int'(err24), 1);
    check("rej_wr_busy", int'(busy24), 1);
    tick();
    check("rej_wr_ack_pulse", int'(ack24), 0);
    check("rej_wr_err_clear", int'(err24), 0);
    check("rej_wr_busy_clear", int'(busy24), 0);
    rd24 = 1'b1; addr24 = 5'd24;
    tick();
    rd24 = 1'b0;
    check("rej_rd_ack", int'(ack24), 1);
    check("rej_rd_err", int'(err24), 1);
    check("rej_rd_rdata", int'(rdata24), 0);
    tick();
    check("rej_rd_ack_pulse", int'(ack24), 0);
    for (int i = 0; i < S24 + 2; i++) begin
      check_head();
      tick();
    end

    // Directed transactions.
    for (int v = 0; v < 7; v++) begin
      cen = 1'b1;
      for (int g = 0; g < 2 * S && m_cnt != vecs[v].start; g++) begin
        check_head();
        tick();
      end
      do_op(vecs[v].w, vecs[v].r, vecs[v].a, vecs[v].d,
            vecs[v].edges, vecs[v].rdata, vecs[v].junk);
    end

    // Randomized transactions with random idle gaps and cen patterns.
    for (int n = 0; n < 30; n++) begin
      int gap, a, d, sel, edges;
      bit w, r;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        cen = 1'($urandom_range(0, 1));
        check_head();
        tick();
      end
      a   = $urandom_range(0, S - 1);
      d   = $urandom_range(0, 31);
      sel = $urandom_range(0, 2);
      w   = (sel != 1);
      r   = (sel != 0);
      edges = ((a - m_cnt - 1 + 2 * S) % S) + 1;
      do_op(w, r, a, d, edges, w ? 0 : m_ring[a], 1'($urandom_range(0, 1)));
    end

    // Stalled write, then reset drops it without ack and clears the ring.
    cen = 1'b0; wr_req = 1'b1; addr = 5'd7; wdata = 5'd9;
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("stall_busy", int'(busy), 1);
      check("stall_ack", int'(ack), 0);
      check_head();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy", int'(busy), 0);
    check("rst2_ack", int'(ack), 0);
    check("rst2_rdata", int'(rdata), 0);
    cen = 1'b1;
    for (int i = 0; i < S + 4; i++) begin
      check("post_rst_ack", int'(ack), 0);
      check("post_rst_busy", int'(busy), 0);
      check_head();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
